// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - WIDTH-bit adder with carry chain split into STAGES valid/ready pipeline chunks
// Optional subtract path enabled by defining PIPE_ADDER_SUB_EN.
module pipelined_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef PIPE_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int CW = WIDTH / STAGES;

    logic [WIDTH-1:0]  b_eff;
    logic              cin_eff;
    logic [STAGES-1:0] valid;
    logic [STAGES-1:0] adv;
    logic              accept;

`ifdef PIPE_ADDER_SUB_EN
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = sub | cin;
`else
    assign b_eff   = b;
    assign cin_eff = cin;
`endif

    // Advance resolves from the output end backwards so a full pipe can shift in one cycle.
    always_comb begin
        logic nxt;
        adv           = '0;
        nxt           = valid[STAGES-1] && out_ready;
        adv[STAGES-1] = nxt;
        for (int k = STAGES - 2; k >= 0; k--) begin
            nxt    = valid[k] && (!valid[k+1] || nxt);
            adv[k] = nxt;
        end
    end

    assign in_ready = !valid[0] || adv[0];
    assign accept   = in_valid && in_ready;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int RW = WIDTH - k * CW;
        localparam int DW = (k + 1) * CW;

        logic [RW-1:0] a_in;
        logic [RW-1:0] b_in;
        logic          c_in;
        logic          load;
        logic [CW:0]   chunk;
        logic [DW-1:0] sum_d;
        logic [DW-1:0] sum_q;
        logic          carry_q;
        logic          valid_q;

        if (k == 0) begin : g_src
            assign a_in  = a;
            assign b_in  = b_eff;
            assign c_in  = cin_eff;
            assign load  = accept;
            assign sum_d = chunk[CW-1:0];
        end else begin : g_src
            assign a_in  = g_stage[k-1].g_fwd.a_q;
            assign b_in  = g_stage[k-1].g_fwd.b_q;
            assign c_in  = g_stage[k-1].carry_q;
            assign load  = adv[k-1];
            assign sum_d = {chunk[CW-1:0], g_stage[k-1].sum_q};
        end

        assign chunk    = {1'b0, a_in[CW-1:0]} + {1'b0, b_in[CW-1:0]} + {{CW{1'b0}}, c_in};
        assign valid[k] = valid_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
                carry_q <= 1'b0;
                sum_q   <= '0;
            end else if (load) begin
                valid_q <= 1'b1;
                carry_q <= chunk[CW];
                sum_q   <= sum_d;
            end else if (adv[k]) begin
                valid_q <= 1'b0;
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            // Only the operand chunks not yet added travel onward.
            logic [RW-CW-1:0] a_q;
            logic [RW-CW-1:0] b_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (load) begin
                    a_q <= a_in[RW-1:CW];
                    b_q <= b_in[RW-1:CW];
                end
            end
        end else begin : g_out
            logic a_msb_q;
            logic b_msb_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    a_msb_q <= 1'b0;
                    b_msb_q <= 1'b0;
                end else if (load) begin
                    a_msb_q <= a_in[CW-1];
                    b_msb_q <= b_in[CW-1];
                end
            end
            assign out_valid = valid_q;
            assign sum       = sum_q;
            assign cout      = carry_q;
            assign ovf       = (a_msb_q == b_msb_q) && (sum_q[DW-1] != a_msb_q);
        end
    end

endmodule

// File: tb/tb_pipelined_adder.sv
// tb/tb_pipelined_adder.sv - scoreboard bench for pipelined_adder against an arithmetic reference model
module tb_pipelined_adder;
    localparam int WIDTH  = 16;
    localparam int STAGES = 4;
`ifdef PIPE_ADDER_SUB_EN
    localparam bit HAS_SUB = 1'b1;
`else
    localparam bit HAS_SUB = 1'b0;
`endif

    typedef struct packed {
        logic [WIDTH-1:0] s;
        logic             c;
        logic             o;
    } exp_t;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             in_valid  = 1'b0;
    logic             out_ready = 1'b1;
    logic             cin       = 1'b0;
    logic [WIDTH-1:0] a         = '0;
    logic [WIDTH-1:0] b         = '0;
`ifdef PIPE_ADDER_SUB_EN
    logic             sub       = 1'b0;
`endif
    logic             in_ready;
    logic             out_valid;
    logic             cout;
    logic             ovf;
    logic [WIDTH-1:0] sum;

    int vectors  = 0;
    int errors   = 0;
    int cyc      = 0;
    int npop     = 0;
    int run      = 0;
    int max_run  = 0;
    int last_pop = -10;
    int acc_cyc  = 0;
    bit done     = 1'b0;
    bit stalled  = 1'b0;
    logic [WIDTH+1:0] hold = '0;
    exp_t exp_q[$];

    pipelined_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef PIPE_ADDER_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic c, input logic s);
        longint m  = longint'(1) << WIDTH;
        longint ux = longint'(x);
        longint uy = longint'(y);
        longint sx = (ux >= m / 2) ? ux - m : ux;
        longint sy = (uy >= m / 2) ? uy - m : uy;
        longint tot;
        longint st;
        exp_t   e;
        if (s) begin
            tot = ux + (m - uy);
            st  = sx - sy;
        end else begin
            tot = ux + uy + longint'(c);
            st  = sx + sy + longint'(c);
        end
        e.s = tot[WIDTH-1:0];
        e.c = (tot >= m);
        e.o = (st >= m / 2) || (st < -(m / 2));
        return e;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            stalled = 1'b0;
        end else begin
            if (stalled)
                check("hold_stable", 64'({out_valid, cout, ovf, sum}), 64'({1'b1, hold}));
            if (out_valid && out_ready) begin
                check("sb_nonempty", 64'(exp_q.size() > 0), 64'(1));
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("sum", 64'(sum), 64'(e.s));
                    check("cout", 64'(cout), 64'(e.c));
                    check("ovf", 64'(ovf), 64'(e.o));
                end
                npop++;
                run      = (cyc == last_pop + 1) ? run + 1 : 1;
                last_pop = cyc;
                if (run > max_run) max_run = run;
            end
            stalled = out_valid && !out_ready;
            hold    = {cout, ovf, sum};
        end
    end

    task automatic send(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                        input logic c, input logic s);
        int n = 0;
        a   = x;
        b   = y;
        cin = c;
`ifdef PIPE_ADDER_SUB_EN
        sub = s;
`endif
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 1000);
        if (!in_ready) begin
            check("accept_timeout", 64'(in_ready), 64'(1));
            in_valid = 1'b0;
        end else begin
            exp_q.push_back(model(x, y, c, s));
            acc_cyc = cyc + 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_rand();
        send(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(1)),
             HAS_SUB ? 1'($urandom_range(1)) : 1'b0);
    endtask

    task automatic single(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic c,
                          input logic s, input logic [WIDTH-1:0] es, input logic ec, input logic eo);
        int p0 = npop;
        int n  = 0;
        send(x, y, c, s);
        in_valid = 1'b0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 20);
        check("latency", 64'(cyc - acc_cyc), 64'(STAGES - 1));
        check("dir_sum", 64'(sum), 64'(es));
        check("dir_cout", 64'(cout), 64'(ec));
        check("dir_ovf", 64'(ovf), 64'(eo));
        repeat (STAGES + 2) @(posedge clk);
        #1;
        check("single_count", 64'(npop - p0), 64'(1));
    endtask

    initial begin
        int p0;
        int acc;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_sum", 64'(sum), 64'(0));
        check("rst_cout_ovf", 64'({cout, ovf}), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        single(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        single(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        single(16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);
`ifdef PIPE_ADDER_SUB_EN
        single(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        single(16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);
`endif

        p0      = npop;
        max_run = 0;
        for (int i = 0; i < 16; i++) send_rand();
        in_valid = 1'b0;
        repeat (STAGES + 3) @(posedge clk);
        #1;
        check("burst_count", 64'(npop - p0), 64'(16));
        check("burst_run", 64'(max_run), 64'(16));

        p0        = npop;
        acc       = 0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
`ifdef PIPE_ADDER_SUB_EN
        sub = 1'b0;
`endif
        for (int i = 0; i < 8; i++) begin
            a   = WIDTH'($urandom);
            b   = WIDTH'($urandom);
            cin = 1'($urandom_range(1));
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(model(a, b, cin, 1'b0));
                acc++;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        check("stall_accepts", 64'(acc), 64'(STAGES));
        check("stall_in_ready", 64'(in_ready), 64'(0));
        check("stall_no_emit", 64'(npop - p0), 64'(0));
        out_ready = 1'b1;
        repeat (STAGES + 2) @(posedge clk);
        #1;
        check("stall_drain", 64'(npop - p0), 64'(STAGES));

        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send_rand();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("flush_out_valid", 64'(out_valid), 64'(0));
        check("flush_sum", 64'(sum), 64'(0));
        exp_q.delete();
        p0 = npop;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        check("flush_in_ready", 64'(in_ready), 64'(1));
        repeat (STAGES + 4) @(posedge clk);
        #1;
        check("flush_no_emit", 64'(npop - p0), 64'(0));

        p0 = npop;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    if ($urandom_range(3) == 0) begin
                        in_valid = 1'b0;
                        @(posedge clk);
                        #1;
                    end
                    send_rand();
                end
                in_valid = 1'b0;
                done     = 1'b1;
            end
            begin
                while (!done) begin
                    out_ready = 1'($urandom_range(1));
                    @(posedge clk);
                    #1;
                end
            end
        join
        out_ready = 1'b1;
        repeat (STAGES + 4) @(posedge clk);
        #1;
        check("random_count", 64'(npop - p0), 64'(1000));
        check("drained", 64'(exp_q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1);
    end

endmodule
